// File: rtl/mem_trace_pkg.sv
// Shared types and constants for the memory-write trace transmitter.
//   trace_rec_t : one captured write {cycle, addr, data}, 96 bits, sent MSB first
//   REC_BYTES   : bytes per serialized record
//   END_ADDR    : address field marking the end-of-trace record
//   tx_state_t  : serializer FSM states
package mem_trace_pkg;

  localparam int          REC_BYTES = 12;
  localparam logic [31:0] END_ADDR  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    END,
    DONE
  } tx_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO between the write snooper and the byte serializer.
//   clk, reset : clock, asynchronous active-low reset
//   push/wdata : enqueue a record (ignored when full unless popping this edge)
//   pop/rdata  : dequeue; rdata always shows the head record
//   empty/full : occupancy flags, derived from the registered pointers
module trace_fifo
  import mem_trace_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = trace_rec_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  // The extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;
  rec_t        mem [DEPTH];

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_trace_tx.sv
// Memory-write trace transmitter. Snoops data-memory writes of the core,
// timestamps and queues them, and streams each as a 12-byte record over a
// valid/ready byte interface. When the core reaches pc_finished, an end
// record {cyc, FFFFFFFF, pc_finished} follows the queued records.
//   clk, reset          : clock, asynchronous active-low reset
//   pc, pc_finished     : core PC and the PC that ends the trace
//   memwrite/aluout/writedata : snooped data-memory write
//   tx_valid/tx_data/tx_last/tx_ready : byte stream, tx_last on byte 11
//   full      : record FIFO full
//   overflow  : sticky, a write was dropped because the FIFO was full
//   done      : end record sent, stream closed until reset
module mem_trace_tx
  import mem_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] pc_finished,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        full,
  output logic        overflow,
  output logic        done
);

  localparam int         RW       = $bits(trace_rec_t);
  localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

  logic          finish, fin_l, capture, pop, fifo_empty;
  logic [31:0]   cyc;
  trace_rec_t    push_rec, head_rec;
  tx_state_t     state, state_n;
  logic [3:0]    idx, idx_n;
  logic [RW-1:0] sr, sr_n;

  assign finish  = (pc == pc_finished);
  assign capture = memwrite && !finish;
  // Stamp with the value cyc takes on this same edge.
  assign push_rec = '{cycle: cyc + 32'd1, addr: aluout, data: writedata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc      <= '0;
      fin_l    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (finish)            fin_l    <= 1'b1;
      if (!fin_l && !finish) cyc      <= cyc + 32'd1;
      if (capture && full && !pop) overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .wdata (push_rec),
    .rdata (head_rec),
    .empty (fifo_empty),
    .full  (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sr    <= sr_n;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sr_n    = sr;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        // Queued writes always go out before the end record.
        if (!fifo_empty) begin
          pop     = 1'b1;
          sr_n    = head_rec;
          idx_n   = '0;
          state_n = SEND;
        end else if (fin_l) begin
          sr_n    = {cyc, END_ADDR, pc_finished};
          idx_n   = '0;
          state_n = END;
        end
      end
      SEND, END: begin
        if (tx_ready) begin
          sr_n = {sr[RW-9:0], 8'h00};
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            state_n = (state == SEND) ? IDLE : DONE;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
  end

  // The current byte is the top of the shift register, so tx_data and
  // tx_last come straight from flops and hold while tx_ready is low.
  assign tx_valid = (state == SEND) || (state == END);
  assign tx_data  = sr[RW-1 -: 8];
  assign tx_last  = tx_valid && (idx == LAST_IDX);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_mem_trace_tx.sv
// Self-checking bench for mem_trace_tx. A reference model derived from the
// trace rules predicts the record stream; a monitor collects transferred bytes.
module tb_mem_trace_tx;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] PC_FIN = 32'h0000_003C;
  localparam logic [31:0] PC_RUN = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, pc_finished, aluout, writedata;
  logic        memwrite, tx_ready;
  logic        tx_valid, tx_last, full, overflow, done;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [95:0] exp_q[$];
  logic [7:0]  rx_bytes[$];
  logic        rx_last[$];
  int          rx_time[$];
  logic [31:0] mcyc;
  bit          mfin;
  int          tb_cyc = 0;

  mem_trace_tx #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_finished (pc_finished),
    .memwrite    (memwrite),
    .aluout      (aluout),
    .writedata   (writedata),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .full        (full),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Inputs change just after a rising edge, so at the falling edge they are
  // exactly what the next rising edge samples: model that edge and log any
  // byte that will be handshaken on it.
  always @(negedge clk) begin
    tb_cyc <= tb_cyc + 1;
    if (!reset) begin
      mcyc <= '0;
      mfin <= 1'b0;
    end else begin
      if (pc == PC_FIN) begin
        if (!mfin) exp_q.push_back({mcyc, 32'hFFFF_FFFF, PC_FIN});
        mfin <= 1'b1;
      end else begin
        if (memwrite) exp_q.push_back({mcyc + 32'd1, aluout, writedata});
        if (!mfin) mcyc <= mcyc + 32'd1;
      end
      if (tx_valid && tx_ready) begin
        rx_bytes.push_back(tx_data);
        rx_last.push_back(tx_last);
        rx_time.push_back(tb_cyc);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    aluout    = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic flush_rx();
    rx_bytes.delete();
    rx_last.delete();
    rx_time.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (rx_bytes.size() < n && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (rx_bytes.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d bytes, need %0d", name, rx_bytes.size(), n);
    end
  endtask

  task automatic pop_rec(output logic [95:0] rec, output logic [11:0] lasts);
    rec   = '0;
    lasts = '0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       l;
      if (rx_bytes.size() > 0) begin
        b = rx_bytes.pop_front();
        l = rx_last.pop_front();
        void'(rx_time.pop_front());
      end else begin
        b = 'x;
        l = 1'bx;
      end
      rec   = {rec[87:0], b};
      lasts = {lasts[10:0], l};
    end
  endtask

  function automatic logic [95:0] next_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic test_reset();
    reset       = 1'b0;
    pc          = PC_RUN;
    pc_finished = PC_FIN;
    memwrite    = 1'b0;
    aluout      = '0;
    writedata   = '0;
    tx_ready    = 1'b0;
    #12;
    n_checks++;
    if ({tx_valid, tx_data, tx_last, full, overflow, done} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {tx_valid, tx_data, tx_last, full, overflow, done});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    logic [95:0] rec, e;
    logic [11:0] lasts;
    tx_ready = 1'b1;
    flush_rx();
    idle(2);
    drive_write(32'h54, 32'h7);
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: tx_valid got %b, expected 0", tx_valid);
    end
    step();
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL latency_byte0: valid/data got %b/%h, expected 1/00", tx_valid, tx_data);
    end
    wait_bytes(12, 40, "single");
    pop_rec(rec, lasts);
    e = next_exp();
    n_checks++;
    if (rec !== 96'h00000003_00000054_00000007) begin
      n_fail++;
      $display("FAIL single_record: got %h, expected 000000030000005400000007", rec);
    end
    n_checks++;
    if (rec !== e) begin
      n_fail++;
      $display("FAIL single_model: got %h, expected %h", rec, e);
    end
    n_checks++;
    if (lasts !== 12'h001) begin
      n_fail++;
      $display("FAIL single_last: got %b, expected 000000000001", lasts);
    end
  endtask

  task automatic test_random_writes();
    logic [95:0] rec, e;
    logic [11:0] lasts;
    for (int r = 0; r < 2; r++) begin
      flush_rx();
      for (int k = 0; k < 6; k++) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        drive_write($urandom, $urandom);
        repeat ($urandom_range(0, 3)) begin
          tx_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
      tx_ready = 1'b1;
      wait_bytes(6 * 12, 400, "random");
      for (int k = 0; k < 6; k++) begin
        pop_rec(rec, lasts);
        e = next_exp();
        n_checks++;
        if (rec !== e || lasts !== 12'h001) begin
          n_fail++;
          $display("FAIL random_rec%0d_%0d: got %h last %b, expected %h last 000000000001",
                   r, k, rec, lasts, e);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL random_overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] rec, e;
    logic [11:0] lasts;
    logic [7:0]  held;
    tx_ready = 1'b1;
    flush_rx();
    drive_write($urandom, $urandom);
    wait_bytes(5, 40, "bp_mid");
    tx_ready = 1'b0;
    held = tx_data;
    e = (exp_q.size() > 0) ? exp_q[0] : 'x;
    n_checks++;
    if (held !== e[55:48]) begin
      n_fail++;
      $display("FAIL bp_byte5: got %h, expected %h", held, e[55:48]);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== held) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid/data got %b/%h, expected 1/%h", i, tx_valid, tx_data, held);
      end
    end
    tx_ready = 1'b1;
    wait_bytes(12, 40, "bp_end");
    idle(5);
    n_checks++;
    if (rx_bytes.size() !== 12) begin
      n_fail++;
      $display("FAIL bp_count: got %0d bytes, expected 12", rx_bytes.size());
    end
    pop_rec(rec, lasts);
    e = next_exp();
    n_checks++;
    if (rec !== e || lasts !== 12'h001) begin
      n_fail++;
      $display("FAIL bp_record: got %h last %b, expected %h", rec, lasts, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] rec, e;
    logic [11:0] lasts;
    tx_ready = 1'b1;
    flush_rx();
    for (int k = 0; k < 3; k++) drive_write($urandom, $urandom);
    wait_bytes(36, 80, "b2b");
    n_checks++;
    if (rx_bytes.size() >= 36 &&
        (rx_time[1] - rx_time[0] != 1 || rx_time[12] - rx_time[11] != 2 ||
         rx_time[24] - rx_time[23] != 2 || rx_time[35] - rx_time[0] != 37)) begin
      n_fail++;
      $display("FAIL b2b_timing: gaps %0d %0d %0d span %0d, expected 1 2 2 37",
               rx_time[1] - rx_time[0], rx_time[12] - rx_time[11],
               rx_time[24] - rx_time[23], rx_time[35] - rx_time[0]);
    end
    for (int k = 0; k < 3; k++) begin
      pop_rec(rec, lasts);
      e = next_exp();
      n_checks++;
      if (rec !== e || lasts !== 12'h001) begin
        n_fail++;
        $display("FAIL b2b_rec%0d: got %h last %b, expected %h", k, rec, lasts, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [95:0] rec, e;
    logic [11:0] lasts;
    flush_rx();
    tx_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) drive_write($urandom, $urandom);
    n_checks++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flags: full/overflow got %b/%b, expected 1/1", full, overflow);
    end
    tx_ready = 1'b1;
    wait_bytes((DEPTH + 1) * 12, 300, "ovf_drain");
    idle(20);
    n_checks++;
    if (rx_bytes.size() !== (DEPTH + 1) * 12) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d bytes, expected %0d", rx_bytes.size(), (DEPTH + 1) * 12);
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      pop_rec(rec, lasts);
      e = next_exp();
      n_checks++;
      if (rec !== e || lasts !== 12'h001) begin
        n_fail++;
        $display("FAIL ovf_rec%0d: got %h last %b, expected %h", k, rec, lasts, e);
      end
    end
    // The last write found the FIFO full and was dropped.
    exp_q.delete();
    n_checks++;
    if (full !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after: full/overflow got %b/%b, expected 0/1", full, overflow);
    end
  endtask

  task automatic test_finish();
    logic [95:0] rec[3];
    logic [95:0] e;
    logic [11:0] lasts;
    flush_rx();
    tx_ready = 1'b1;
    drive_write($urandom, $urandom);
    drive_write($urandom, $urandom);
    pc = PC_FIN;
    drive_write($urandom, $urandom);
    wait_bytes(36, 200, "finish");
    idle(5);
    n_checks++;
    if (rx_bytes.size() !== 36) begin
      n_fail++;
      $display("FAIL fin_count: got %0d bytes, expected 36", rx_bytes.size());
    end
    for (int k = 0; k < 3; k++) begin
      pop_rec(rec[k], lasts);
      e = next_exp();
      n_checks++;
      if (rec[k] !== e || lasts !== 12'h001) begin
        n_fail++;
        $display("FAIL fin_rec%0d: got %h last %b, expected %h", k, rec[k], lasts, e);
      end
    end
    n_checks++;
    if (rec[2][63:0] !== {32'hFFFF_FFFF, PC_FIN} || rec[2][95:64] !== rec[1][95:64]) begin
      n_fail++;
      $display("FAIL fin_endrec: got %h, expected cycle %h addr FFFFFFFF data 0000003C",
               rec[2], rec[1][95:64]);
    end
    n_checks++;
    if (done !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fin_done: done/valid got %b/%b, expected 1/0", done, tx_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [95:0] rec, e;
    logic [11:0] lasts;
    logic [31:0] a, d;
    pc = PC_RUN;
    reset = 1'b0;
    step();
    reset = 1'b1;
    flush_rx();
    exp_q.delete();
    tx_ready = 1'b1;
    drive_write($urandom, $urandom);
    wait_bytes(5, 40, "rst_mid");
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({tx_valid, tx_data, tx_last, full, overflow, done} !== 13'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h, expected 0",
               {tx_valid, tx_data, tx_last, full, overflow, done});
    end
    @(posedge clk);
    #1;
    flush_rx();
    exp_q.delete();
    reset = 1'b1;
    a = $urandom;
    d = $urandom;
    drive_write(a, d);
    wait_bytes(12, 40, "rst_restart");
    pop_rec(rec, lasts);
    e = next_exp();
    n_checks++;
    if (rec !== {32'd1, a, d} || rec !== e) begin
      n_fail++;
      $display("FAIL rst_restart: got %h, expected %h", rec, {32'd1, a, d});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_random_writes();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_finish();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
